bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Downstream consumer of the cascaded 4-bit decade counter stages. Captures the
//  BCD digits those counters produce and time-multiplexes them onto a common
//  7-segment display: one digit lit at a time, with a one-cycle anti-ghost blank
//  between digits and optional leading-zero blanking.
// PARAMETERS
//  NUM_DIGITS   4     digits scanned, legal 2..8; digit 0 = least significant
//  REFRESH_DIV  1000  clocks per digit slot incl. blank cycle, legal >= 2
//  SEG_ACT_LOW  1     1: output_SEG / output_AN active-low; 0: active-high
// PORTS
//  input_CLK      in   1             single clock, rising edge
//  input_RSTN     in   1             async active-low reset
//  input_LOAD     in   1             capture strobe for input_BCD, sampled on rising edge
//  input_BCD      in   4*NUM_DIGITS  packed digits; digit k = [4k+3:4k]
//  input_BLANK_LZ in   1             1: suppress leading zeros (digit 0 never blanked)
//  output_AN      out  NUM_DIGITS    one-hot anode select (polarity per SEG_ACT_LOW)
//  output_SEG     out  7             segments {g,f,e,d,c,b,a}
//  output_IDX     out  3             index of digit currently driven
// BEHAVIOUR
//  Reset (async, input_RSTN=0): prescaler=0, idx=0, latched digits=0, phase=BLANK,
//    output_AN and output_SEG all inactive, output_IDX=0. Deassert is sampled
//    synchronously.
//  Prescaler: counts 0..REFRESH_DIV-1 and wraps; tick = (count==REFRESH_DIV-1).
//  FSM, 2 states:
//    BLANK: AN/SEG inactive for exactly 1 cycle -> SHOW (idx unchanged).
//    SHOW : drive digit idx until tick; on tick idx <= (idx==NUM_DIGITS-1)?0:idx+1,
//           prescaler wraps to 0, state -> BLANK.
//    Each slot = 1 BLANK cycle + REFRESH_DIV-1 SHOW cycles.
//  Outputs are registered: AN/SEG/IDX reflect state, idx and latched data one
//    clock after they change. First SHOW of digit 0 is visible on the 2nd rising
//    edge after reset release.
//  Capture: on an input_LOAD=1 edge, all digits are latched atomically. A LOAD that
//    coincides with tick or a BLANK cycle is not lost; the next SHOW uses new data.
//    A LOAD during SHOW updates the lit digit's segments on the following clock.
//  Decode (active-high form; inverted when SEG_ACT_LOW=1):
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; 10..15 -> dash 40
//    (non-BCD is flagged visibly, never blanked).
//  Leading-zero blanking (input_BLANK_LZ=1): digit k>0 blanked (SEG inactive,
//    AN still asserted) iff digits k..NUM_DIGITS-1 all equal 0. Evaluated on
//    latched data; input_BLANK_LZ is read live.
//  output_IDX follows idx in both BLANK and SHOW.
//  Reset mid-slot: immediate return to reset values; scan restarts at digit 0.
// TESTING
//  T1 reset: RSTN=0 mid-SHOW with LOAD held -> AN=4'hF, SEG=7'h7F, IDX=0 at once;
//     after release, digit 0 lit on 2nd edge.
//  T2 scan (DIV=4, BCD=16'h1234, LOAD pulse): AN cycles E,D,B,7,E...; each slot
//     is 1 cycle AN=F then 3 cycles lit; SEG ~06/~5B/~4F/~66 for IDX 3/2/1/0.
//  T3 LZ: BCD=16'h0070, BLANK_LZ=1 -> digits 3,2 blanked, digit 1 = ~07, digit 0
//     = ~3F; BCD=0 -> only digit 0 shows ~3F.
//  T4 non-BCD: BCD=16'hA9F0 -> digits 3,1 show ~40, digit 2 ~6F, digit 0 ~3F.
//  T5 LOAD on the tick edge (1234 -> 5678): next lit digit shows new value;
//     a LOAD mid-SHOW changes SEG one clock later while AN is unchanged.
//  T6 wrap: run 3*NUM_DIGITS slots; IDX sequence 0..3 repeats; exactly one AN
//     asserted in every SHOW cycle and none in every BLANK cycle.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for latched BCD digits.
// Each digit slot is one blank cycle followed by REFRESH_DIV-1 lit cycles. All outputs are registered.
module bcd_display_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic                    input_CLK,
  input  logic                    input_RSTN,
  input  logic                    input_LOAD,
  input  logic [4*NUM_DIGITS-1:0] input_BCD,
  input  logic                    input_BLANK_LZ,
  output logic [NUM_DIGITS-1:0]   output_AN,
  output logic [6:0]              output_SEG,
  output logic [2:0]              output_IDX
);

  localparam int unsigned          CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0]      CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [2:0]           IdxMax = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]           SegPol = {7{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] AnPol = {NUM_DIGITS{SEG_ACT_LOW}};

  typedef enum logic {StBlank, StShow} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [2:0]              idx_q;
  logic [4*NUM_DIGITS-1:0] digits_q;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [3:0]            cur_digit;
  logic                  cur_upper_zero;
  logic                  zero_run;
  logic                  lz_blank;
  logic [6:0]            seg_hi;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-BCD shows a dash rather than going dark
    endcase
    return s;
  endfunction

  // upper_zero[k]: digits k..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run & (digits_q[4*k +: 4] == 4'd0);
      upper_zero[k] = zero_run;
    end
  end

  always_comb begin
    cur_digit      = 4'd0;
    cur_upper_zero = 1'b0;
    an_onehot      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        cur_digit      = digits_q[4*k +: 4];
        cur_upper_zero = upper_zero[k];
        an_onehot[k]   = 1'b1;
      end
    end
    lz_blank = input_BLANK_LZ && (idx_q != 3'd0) && cur_upper_zero;
    seg_hi   = ((state_q == StShow) && !lz_blank) ? decode(cur_digit) : 7'h00;
  end

  always_ff @(posedge input_CLK or negedge input_RSTN) begin
    if (!input_RSTN) begin
      state_q    <= StBlank;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      digits_q   <= '0;
      output_AN  <= AnPol;
      output_SEG <= SegPol;
      output_IDX <= 3'd0;
    end else begin
      if (input_LOAD) digits_q <= input_BCD;

      output_AN  <= ((state_q == StShow) ? an_onehot : '0) ^ AnPol;
      output_SEG <= seg_hi ^ SegPol;
      output_IDX <= idx_q;

      unique case (state_q)
        StBlank: begin
          state_q <= StShow;
          cnt_q   <= cnt_q + CntW'(1);
        end
        StShow: begin
          if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            idx_q   <= (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
            state_q <= StBlank;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StBlank;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: directed scenarios then random loads/resets,
// checked every cycle against a slot-arithmetic reference model.
module tb_bcd_display_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blz = 1'b0;
  logic [15:0] bcd = 16'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [2:0]  idx;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          s = 0;           // cycles of scan state elapsed since reset release
  logic [15:0] data_m = 16'h0;  // model of latched digits

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV),
    .SEG_ACT_LOW(1'b1)
  ) dut (
    .input_CLK     (clk),
    .input_RSTN    (rst_n),
    .input_LOAD    (load),
    .input_BCD     (bcd),
    .input_BLANK_LZ(blz),
    .output_AN     (an),
    .output_SEG    (seg),
    .output_IDX    (idx)
  );

  // Display content expected one clock after scan time st.
  function automatic void model(input int st, input logic [15:0] d, input logic lz,
                                output logic [3:0] e_an, output logic [6:0] e_seg,
                                output logic [2:0] e_idx);
    int p;
    int i;
    logic [15:0] hi;
    p     = st % DIV;
    i     = (st / DIV) % N;
    e_idx = 3'(i);
    if (p == 0) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
    end else begin
      e_an = ~(4'b0001 << i);
      hi   = d >> (4 * i);
      if (lz && i > 0 && hi == 16'h0) e_seg = 7'h7F;
      else                            e_seg = ~segtab[hi[3:0]];
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (scan time %0d)", tag, obs, exp, s);
    end
  endtask

  // Called at a negedge; drives inputs over one rising edge and checks outputs.
  task automatic step(input logic ld, input logic [15:0] v, input logic lz);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [2:0] e_idx;
    load = ld;
    bcd  = v;
    blz  = lz;
    model(s, data_m, lz, e_an, e_seg, e_idx);
    @(posedge clk);
    if (ld) data_m = v;
    s++;
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("idx", 32'(idx), 32'(e_idx));
  endtask

  // Asynchronous reset in mid-cycle with LOAD held, then release.
  task automatic do_reset(input logic [15:0] v);
    #2;
    rst_n = 1'b0;
    load  = 1'b1;
    bcd   = v;
    #1;
    check("rst_an", 32'(an), 32'h0000_000F);
    check("rst_seg", 32'(seg), 32'h0000_007F);
    check("rst_idx", 32'(idx), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_an", 32'(an), 32'h0000_000F);
    load   = 1'b0;
    rst_n  = 1'b1;
    s      = 0;
    data_m = 16'h0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("por_an", 32'(an), 32'h0000_000F);
    check("por_seg", 32'(seg), 32'h0000_007F);
    rst_n = 1'b1;

    // Scan of 1234.
    step(1'b1, 16'h1234, 1'b0);
    repeat (3 * N * DIV) step(1'b0, 16'h1234, 1'b0);

    // Leading-zero blanking.
    step(1'b1, 16'h0070, 1'b1);
    repeat (2 * N * DIV) step(1'b0, 16'h0070, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    repeat (2 * N * DIV) step(1'b0, 16'h0000, 1'b1);

    // Non-BCD digits.
    step(1'b1, 16'hA9F0, 1'b0);
    repeat (2 * N * DIV) step(1'b0, 16'hA9F0, 1'b0);

    // LOAD on the tick edge, then a LOAD in the middle of a lit slot.
    step(1'b1, 16'h1234, 1'b0);
    while ((s % DIV) != DIV - 1) step(1'b0, 16'h1234, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    repeat (DIV + 1) step(1'b0, 16'h5678, 1'b0);
    while ((s % DIV) != 1) step(1'b0, 16'h5678, 1'b0);
    step(1'b1, 16'h9999, 1'b0);
    repeat (N * DIV) step(1'b0, 16'h9999, 1'b0);

    // Reset in mid-SHOW with LOAD held; digit 0 lit on 2nd edge after release.
    while ((s % DIV) != 2) step(1'b0, 16'h9999, 1'b0);
    do_reset(16'h4321);
    step(1'b0, 16'h4321, 1'b0);
    step(1'b0, 16'h4321, 1'b0);
    check("first_lit_an", 32'(an), 32'h0000_000E);
    repeat (3 * N * DIV) step(1'b0, 16'h4321, 1'b0);

    // Random loads, live blanking control and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(16'($urandom));
      end else begin
        step(($urandom_range(0, 5) == 0), 16'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
